mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM among three requesters.
- The requesters are the CPU instruction fetch (I), the CPU load/store unit (D), and the external program loader/debug port (L).
- Sits between the CPU's IA/ID and DA/DD/RW buses (via thin adapters) and the shared memory macro.
- Sequences every access through a fixed issue/wait/acknowledge FSM and replaces separate instruction and data memories.

Parameters:
- AW, 16, address width of all ports.
- DW, 16, data width of all ports.

Ports:
- CK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- IREQ  in  1  instruction-fetch read request.
- IADDR  in  AW  fetch address.
- IRDATA  out  DW  fetch data, valid while IACK=1 and held afterwards.
- IACK  out  1  one-cycle completion pulse for I.
- DREQ  in  1  data request.
- DWE  in  1  data direction: 1=write, 0=read.
- DADDR  in  AW  data address.
- DWDATA  in  DW  data write value.
- DRDATA  out  DW  data read value, valid while DACK=1 and held afterwards.
- DACK  out  1  one-cycle completion pulse for D.
- LREQ  in  1  loader request.
- LWE  in  1  loader direction: 1=write, 0=read.
- LADDR  in  AW  loader address.
- LWDATA  in  DW  loader write value.
- LRDATA  out  DW  loader read value.
- LACK  out  1  one-cycle completion pulse for L.
- MEN  out  1  memory enable.
- MWE  out  1  memory write enable.
- MADDR  out  AW  memory address.
- MWDATA  out  DW  memory write data.
- MRDATA  in  DW  memory read data, valid one cycle after the MEN read cycle.
- OWNER  out  2  current grant: 0=none, 1=I, 2=D, 3=L.

Behaviour:
- Reset (RST=0, asynchronous, any state):
  - State goes to IDLE.
  - MEN, MWE, IACK, DACK, LACK = 0; OWNER = 0.
  - MADDR, MWDATA, IRDATA, DRDATA, LRDATA = 0.
  - Round-robin pointer LAST = I.
  - Any in-flight access is aborted with no ACK; the requester must reissue after reset.
- Outputs: all are registered; no combinational path from any *REQ to any memory-side output.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Samples requests at the rising edge.
  - If any request is pending, latch the winner's address, write data and direction into MADDR/MWDATA/MWE, set MEN=1, set OWNER, go to ISSUE.
  - Otherwise stay in IDLE with MEN=0.
- Arbitration:
  - L has fixed highest priority.
  - Between D and I: if exactly one is requesting, it wins; if both, the one not equal to LAST wins.
  - LAST updates to the winner on every D or I grant; an L grant does not change LAST.
  - After reset, a simultaneous D and I request goes to D first.
- ISSUE (one cycle, MEN=1):
  - The memory captures the access at the end of this cycle.
  - Next state is ACK for writes, WAIT for reads. MEN and MWE drop to 0 leaving ISSUE.
  - I requests are always reads; MWE=0 for I.
- WAIT (one cycle): MRDATA is registered into the owner's xRDATA at the end of WAIT; next state is ACK.
- ACK (one cycle):
  - The owner's xACK = 1 and OWNER is still valid.
  - Next state is IDLE; OWNER returns to 0 and xACK to 0.
- Latency, from the edge that samples REQ in IDLE to the xACK cycle: write = 2 cycles, read = 3 cycles.
- Throughput: one access per 3 cycles (write) or 4 cycles (read).
- Requester protocol:
  - REQ, ADDR, WE and WDATA must be held stable until xACK is seen.
  - A REQ still high in the first IDLE cycle after ACK counts as a new request; back-to-back accesses are legal.
  - Changing the inputs of a non-granted requester while it waits is legal; they are sampled only at grant.
- Requests arriving during ISSUE/WAIT/ACK are not lost; they are evaluated at the next IDLE.
- xRDATA registers hold their last read value until that port's next read completes; writes do not alter them.
- Starvation bound: with L idle, a pending D or I request is granted within 2 grants.

Test Plan:
- I-only read: preload mem[0x0010]=0xA5A5; IREQ=1, IADDR=0x0010 sampled at t0 -> MEN=1 and MADDR=0x0010 in t0..t1; IACK=1 with IRDATA=0xA5A5 in t2..t3; OWNER=1 during t0..t3.
- D write then read: DWE=1, DADDR=0x0042, DWDATA=0x1234 -> MWE=1 during ISSUE, DACK after 2 cycles; then DWE=0 on the same address -> DACK after 3 cycles with DRDATA=0x1234.
- Simultaneous D and I after reset, both held continuously -> grant order D, I, D, I; OWNER sequence 2,1,2,1; IRDATA and DRDATA match memory contents.
- L preemption: D and I pending while L writes 0xBEEF to 0x0001 -> L served first (LACK), then D (LAST=I unchanged by the L grant), then I.
- Reset mid-read: D read to 0x0005 with RST=0 asserted during WAIT -> immediate MEN=0, OWNER=0, DRDATA=0 and no DACK; after release a reissued read completes normally in 3 cycles.
- Idle bus: no requests for 10 cycles -> MEN=0, OWNER=0 and all ACKs 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the three requesters (I, D, L), the arbiter and the
// shared single-port synchronous RAM. The arbiter takes the slave side;
// the environment (requesters plus memory macro) takes the master side.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  // Instruction fetch port (read only)
  logic          IREQ;
  logic [AW-1:0] IADDR;
  logic [DW-1:0] IRDATA;
  logic          IACK;

  // Load/store port
  logic          DREQ;
  logic          DWE;
  logic [AW-1:0] DADDR;
  logic [DW-1:0] DWDATA;
  logic [DW-1:0] DRDATA;
  logic          DACK;

  // Loader/debug port
  logic          LREQ;
  logic          LWE;
  logic [AW-1:0] LADDR;
  logic [DW-1:0] LWDATA;
  logic [DW-1:0] LRDATA;
  logic          LACK;

  // Memory macro side
  logic          MEN;
  logic          MWE;
  logic [AW-1:0] MADDR;
  logic [DW-1:0] MWDATA;
  logic [DW-1:0] MRDATA;

  // Current grant: 0=none, 1=I, 2=D, 3=L
  logic [1:0]    OWNER;

  modport slave (
    input  IREQ, IADDR,
    input  DREQ, DWE, DADDR, DWDATA,
    input  LREQ, LWE, LADDR, LWDATA,
    input  MRDATA,
    output IRDATA, IACK,
    output DRDATA, DACK,
    output LRDATA, LACK,
    output MEN, MWE, MADDR, MWDATA,
    output OWNER
  );

  modport master (
    output IREQ, IADDR,
    output DREQ, DWE, DADDR, DWDATA,
    output LREQ, LWE, LADDR, LWDATA,
    output MRDATA,
    input  IRDATA, IACK,
    input  DRDATA, DACK,
    input  LRDATA, LACK,
    input  MEN, MWE, MADDR, MWDATA,
    input  OWNER
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one single-port synchronous RAM between the
// CPU fetch port (I), the load/store port (D) and the loader port (L).
// Every access walks IDLE -> ISSUE -> (WAIT for reads) -> ACK -> IDLE.
// All outputs come straight from flops, so no request ever reaches the
// memory side combinationally.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic              CK,
  input  logic              RST,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2,
    OWN_L    = 2'd3
  } owner_t;

  state_t        state, state_next;
  owner_t        owner_q, owner_next;

  logic          men_q, men_next;
  logic          mwe_q, mwe_next;
  logic [AW-1:0] maddr_q, maddr_next;
  logic [DW-1:0] mwdata_q, mwdata_next;

  logic          iack_q, iack_next;
  logic          dack_q, dack_next;
  logic          lack_q, lack_next;
  logic [DW-1:0] irdata_q, irdata_next;
  logic [DW-1:0] drdata_q, drdata_next;
  logic [DW-1:0] lrdata_q, lrdata_next;

  // Round-robin memory between D and I: 1 when D was the last of the two
  // to be granted. Reset value 0 means "I went last", so D wins first.
  logic          last_is_d, last_is_d_next;

  logic          d_wins;
  logic          i_wins;

  // D beats I when I is absent, or when both ask and I was served last.
  always_comb begin
    d_wins = bus.DREQ && (!bus.IREQ || !last_is_d);
    i_wins = bus.IREQ && !d_wins;
  end

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_next     = state;
    owner_next     = owner_q;
    men_next       = men_q;
    mwe_next       = mwe_q;
    maddr_next     = maddr_q;
    mwdata_next    = mwdata_q;
    iack_next      = 1'b0;
    dack_next      = 1'b0;
    lack_next      = 1'b0;
    irdata_next    = irdata_q;
    drdata_next    = drdata_q;
    lrdata_next    = lrdata_q;
    last_is_d_next = last_is_d;

    case (state)
      IDLE: begin
        men_next = 1'b0;
        mwe_next = 1'b0;
        if (bus.LREQ) begin
          state_next  = ISSUE;
          owner_next  = OWN_L;
          men_next    = 1'b1;
          mwe_next    = bus.LWE;
          maddr_next  = bus.LADDR;
          mwdata_next = bus.LWDATA;
        end else if (d_wins) begin
          state_next     = ISSUE;
          owner_next     = OWN_D;
          men_next       = 1'b1;
          mwe_next       = bus.DWE;
          maddr_next     = bus.DADDR;
          mwdata_next    = bus.DWDATA;
          last_is_d_next = 1'b1;
        end else if (i_wins) begin
          state_next     = ISSUE;
          owner_next     = OWN_I;
          men_next       = 1'b1;
          mwe_next       = 1'b0;
          maddr_next     = bus.IADDR;
          last_is_d_next = 1'b0;
        end
      end

      ISSUE: begin
        men_next = 1'b0;
        mwe_next = 1'b0;
        if (mwe_q) begin
          state_next = ACK;
          iack_next  = (owner_q == OWN_I);
          dack_next  = (owner_q == OWN_D);
          lack_next  = (owner_q == OWN_L);
        end else begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        state_next = ACK;
        iack_next  = (owner_q == OWN_I);
        dack_next  = (owner_q == OWN_D);
        lack_next  = (owner_q == OWN_L);
        case (owner_q)
          OWN_I:   irdata_next = bus.MRDATA;
          OWN_D:   drdata_next = bus.MRDATA;
          OWN_L:   lrdata_next = bus.MRDATA;
          default: ;
        endcase
      end

      ACK: begin
        state_next = IDLE;
        owner_next = OWN_NONE;
      end

      default: begin
        state_next = IDLE;
        owner_next = OWN_NONE;
        men_next   = 1'b0;
        mwe_next   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      owner_q   <= OWN_NONE;
      men_q     <= 1'b0;
      mwe_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      iack_q    <= 1'b0;
      dack_q    <= 1'b0;
      lack_q    <= 1'b0;
      irdata_q  <= '0;
      drdata_q  <= '0;
      lrdata_q  <= '0;
      last_is_d <= 1'b0;
    end else begin
      state     <= state_next;
      owner_q   <= owner_next;
      men_q     <= men_next;
      mwe_q     <= mwe_next;
      maddr_q   <= maddr_next;
      mwdata_q  <= mwdata_next;
      iack_q    <= iack_next;
      dack_q    <= dack_next;
      lack_q    <= lack_next;
      irdata_q  <= irdata_next;
      drdata_q  <= drdata_next;
      lrdata_q  <= lrdata_next;
      last_is_d <= last_is_d_next;
    end
  end

  assign bus.MEN    = men_q;
  assign bus.MWE    = mwe_q;
  assign bus.MADDR  = maddr_q;
  assign bus.MWDATA = mwdata_q;
  assign bus.OWNER  = owner_q;
  assign bus.IACK   = iack_q;
  assign bus.DACK   = dack_q;
  assign bus.LACK   = lack_q;
  assign bus.IRDATA = irdata_q;
  assign bus.DRDATA = drdata_q;
  assign bus.LRDATA = lrdata_q;

endmodule
